port_shift_out: RTL
===================

Name: port_shift_out

Overview:
- Downstream consumer of the 8-bit output-port register bank.
- Serialises the current 8-bit port value into an external 74HC595-style shift register using three pins: serial data, shift clock and latch clock.
- Retransmits automatically whenever the port value differs from the last value sent, or when software forces a refresh.
- Sits between the port register outputs and the FPGA pins.

Parameters:
CLK_DIV, 2, system clocks per half-period of srclk and of the rclk high pulse; legal range 1..255
MSB_FIRST, 1, 1 = bit 7 shifted first; 0 = bit 0 shifted first

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  reset; asynchronous, active-high
valuePort  input  8  parallel port value from the port register bank
refresh  input  1  one-cycle pulse; forces a retransmit even when the value is unchanged
ser  output  1  serial data to the external register
srclk  output  1  external shift clock
rclk  output  1  external latch clock
busy  output  1  high while a transfer is in progress

Behaviour:
- Reset (asynchronous) values:
  - ser=0, srclk=0, rclk=0, busy=0
  - lastSent=8'h00, shiftReg=8'h00, bitCnt=0, divCnt=0
  - pending=1, so one transfer of the current value follows reset and syncs the external device.
- State machine states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO.
- IDLE:
  - Trigger condition: (valuePort != lastSent) OR pending OR refresh.
  - When the trigger holds at an edge, go to LOAD; busy goes 1 from the next cycle.
  - pending is cleared on entry to LOAD.
- LOAD (1 cycle):
  - snapshot = valuePort; shiftReg = valuePort.
  - bitCnt=0, divCnt=0; go to SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles):
  - srclk=0; ser = shiftReg[7] if MSB_FIRST, else shiftReg[0], stable for the whole phase.
  - Then go to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles):
  - srclk=1; ser held unchanged.
  - On the last cycle: shift shiftReg (left if MSB_FIRST, else right; zero fill) and increment bitCnt.
  - If bitCnt was 7, go to LATCH_HI; otherwise go to SHIFT_LO.
- LATCH_HI (CLK_DIV cycles): srclk=0, rclk=1.
- LATCH_LO (CLK_DIV cycles):
  - rclk=0.
  - On exit: lastSent=snapshot, busy=0, return to IDLE.
- Transfer length:
  - busy high for 1 + 18*CLK_DIV cycles.
  - Exactly 8 srclk rising edges and 1 rclk rising edge per transfer.
- Data sampling:
  - valuePort is sampled only in LOAD.
  - Changes during a transfer do not corrupt the transfer in flight. They are caught by the IDLE compare, which starts a back-to-back transfer (one IDLE cycle between).
- refresh:
  - A pulse during busy sets pending, so exactly one extra transfer follows.
  - Multiple pulses during one transfer still produce only one extra transfer.
- Simultaneous events: refresh plus a value change in IDLE cause a single transfer.
- Reset mid-transfer:
  - All outputs return low immediately; the partial shift is abandoned.
  - pending=1, so a full transfer restarts after reset release.
- rclk and srclk are never high in the same cycle. ser changes only while srclk=0.
- divCnt width is 8 bits; CLK_DIV=1 gives 1-cycle phases.

Optional Feature:
- Macro: PORT_SHIFT_OE_EN
- Defined:
  - Adds output port oe_n (1 bit, active-low output enable for the external register).
  - oe_n resets to 1 and is cleared to 0 on the first completed LATCH_LO after reset.
  - It stays 0 until the next reset, which masks power-up garbage on the external outputs.
- Undefined: no oe_n port; the external OE pin is tied low on the board.

Test Plan:
- Reset release, valuePort=8'h00, CLK_DIV=2, MSB_FIRST=1:
  - One transfer starts; busy high for 37 cycles.
  - 8 srclk rises, all with ser=0; then 1 rclk pulse 2 cycles wide.
  - busy then drops.
- In IDLE, valuePort 8'h00->8'hA5:
  - ser at successive srclk rises = 1,0,1,0,0,1,0,1.
  - rclk pulses once; lastSent=8'hA5; no further transfer.
- MSB_FIRST=0, valuePort=8'h01:
  - First sampled ser=1, remaining seven=0.
- valuePort changes 8'h0F->8'hF0 at bit 3 of a transfer:
  - Current transfer shifts 8'h0F unchanged.
  - After 1 IDLE cycle a second transfer shifts 8'hF0.
- Two refresh pulses during busy with valuePort constant at 8'h3C:
  - Exactly one extra 8'h3C transfer, then IDLE with busy=0.
- rst asserted at bit 5:
  - ser/srclk/rclk/busy go 0 asynchronously before the next clk edge.
  - After release, a full transfer of the current valuePort follows.
  - With PORT_SHIFT_OE_EN, oe_n=1 until that transfer's LATCH_LO completes, then 0.

Source files
------------

// File: rtl/port_shift_out.sv
// Serialises the 8-bit output-port value into an external 74HC595-style register (ser/srclk/rclk).
// Optional PORT_SHIFT_OE_EN adds oe_n, held high after reset until the first completed latch.
module port_shift_out #(
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] valuePort,
    input  logic       refresh,
    output logic       ser,
    output logic       srclk,
    output logic       rclk,
`ifdef PORT_SHIFT_OE_EN
    output logic       oe_n,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShiftLo,
        StShiftHi,
        StLatchHi,
        StLatchLo
    } stateT;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    stateT      stateQ, stateD;
    logic [7:0] divCntQ, divCntD;
    logic [2:0] bitCntQ, bitCntD;
    logic [7:0] shiftRegQ, shiftRegD;
    logic [7:0] snapshotQ, snapshotD;
    logic [7:0] lastSentQ, lastSentD;
    logic       pendingQ, pendingD;
    logic       serQ, serD;
    logic       srclkQ, srclkD;
    logic       rclkQ, rclkD;
    logic       busyQ, busyD;
    logic       phaseEnd;
`ifdef PORT_SHIFT_OE_EN
    logic       oeNQ, oeND;
`endif

    assign phaseEnd = (divCntQ == DivLast);

    always_comb begin
        stateD    = stateQ;
        divCntD   = divCntQ;
        bitCntD   = bitCntQ;
        shiftRegD = shiftRegQ;
        snapshotD = snapshotQ;
        lastSentD = lastSentQ;
        // A refresh outside IDLE is remembered so exactly one extra transfer follows.
        pendingD  = pendingQ | refresh;
`ifdef PORT_SHIFT_OE_EN
        oeND      = oeNQ;
`endif
        case (stateQ)
            StIdle: begin
                if ((valuePort != lastSentQ) || pendingQ || refresh) begin
                    stateD   = StLoad;
                    pendingD = 1'b0;
                end
            end
            StLoad: begin
                snapshotD = valuePort;
                shiftRegD = valuePort;
                bitCntD   = 3'd0;
                divCntD   = 8'd0;
                stateD    = StShiftLo;
            end
            StShiftLo: begin
                if (phaseEnd) begin
                    divCntD = 8'd0;
                    stateD  = StShiftHi;
                end else begin
                    divCntD = divCntQ + 8'd1;
                end
            end
            StShiftHi: begin
                if (phaseEnd) begin
                    divCntD   = 8'd0;
                    shiftRegD = MSB_FIRST ? {shiftRegQ[6:0], 1'b0} : {1'b0, shiftRegQ[7:1]};
                    bitCntD   = bitCntQ + 3'd1;
                    stateD    = (bitCntQ == 3'd7) ? StLatchHi : StShiftLo;
                end else begin
                    divCntD = divCntQ + 8'd1;
                end
            end
            StLatchHi: begin
                if (phaseEnd) begin
                    divCntD = 8'd0;
                    stateD  = StLatchLo;
                end else begin
                    divCntD = divCntQ + 8'd1;
                end
            end
            StLatchLo: begin
                if (phaseEnd) begin
                    divCntD   = 8'd0;
                    lastSentD = snapshotQ;
                    stateD    = StIdle;
`ifdef PORT_SHIFT_OE_EN
                    oeND      = 1'b0;
`endif
                end else begin
                    divCntD = divCntQ + 8'd1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Pin values are decoded from the next state so every output comes straight from a flop.
    always_comb begin
        serD   = 1'b0;
        srclkD = (stateD == StShiftHi);
        rclkD  = (stateD == StLatchHi);
        busyD  = (stateD != StIdle);
        if ((stateD == StShiftLo) || (stateD == StShiftHi)) begin
            serD = MSB_FIRST ? shiftRegD[7] : shiftRegD[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StIdle;
            divCntQ   <= 8'd0;
            bitCntQ   <= 3'd0;
            shiftRegQ <= 8'h00;
            snapshotQ <= 8'h00;
            lastSentQ <= 8'h00;
            pendingQ  <= 1'b1;
            serQ      <= 1'b0;
            srclkQ    <= 1'b0;
            rclkQ     <= 1'b0;
            busyQ     <= 1'b0;
`ifdef PORT_SHIFT_OE_EN
            oeNQ      <= 1'b1;
`endif
        end else begin
            stateQ    <= stateD;
            divCntQ   <= divCntD;
            bitCntQ   <= bitCntD;
            shiftRegQ <= shiftRegD;
            snapshotQ <= snapshotD;
            lastSentQ <= lastSentD;
            pendingQ  <= pendingD;
            serQ      <= serD;
            srclkQ    <= srclkD;
            rclkQ     <= rclkD;
            busyQ     <= busyD;
`ifdef PORT_SHIFT_OE_EN
            oeNQ      <= oeND;
`endif
        end
    end

    assign ser   = serQ;
    assign srclk = srclkQ;
    assign rclk  = rclkQ;
    assign busy  = busyQ;
`ifdef PORT_SHIFT_OE_EN
    assign oe_n  = oeNQ;
`endif

endmodule
